arb_mux: RTL and testbench
==========================

ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter WIDTH, default 32: data width of every channel.
REQ-002 Parameter N, default 4: number of input channels, legal 2..16.
REQ-003 Parameter MODE, default 1: 0 = fixed priority, 1 = round-robin.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  N  per-channel request; bit i belongs to channel i.
REQ-007 in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_ready  output  N  per-channel accept; a channel transfers when its valid and ready are both high.
REQ-009 out_valid  output  1  output register holds a word.
REQ-010 out_data  output  WIDTH  registered winning word.
REQ-011 out_sel  output  clog2(N)  index of the channel that supplied out_data.
REQ-012 out_ready  input  1  downstream accept; the word transfers when out_valid and out_ready are both high.

Function
REQ-013 The output stage SHALL be a single register; load is allowed when out_valid=0 or out_ready=1.
REQ-014 in_ready[i] SHALL be high only for the current grant i, and only while load is allowed; combinational from in_valid, pointer, out_valid and out_ready.
REQ-015 At most one in_ready bit SHALL be high in any cycle; all bits low when no in_valid is high.
REQ-016 Latency SHALL be one cycle: an input accepted in cycle t appears on out_data/out_sel with out_valid=1 in cycle t+1.
REQ-017 On load with no requester, out_valid SHALL go to 0; out_data and out_sel SHALL hold their previous values.
REQ-018 While out_valid=1 and out_ready=0, out_data, out_sel and out_valid SHALL stay stable.
REQ-019 Full throughput is required: with out_ready held at 1 and requests continuously present, one word transfers every cycle.
REQ-020 MODE=0: the lowest-indexed valid channel SHALL win.
REQ-021 MODE=1: the search SHALL start at pointer p and wrap from N-1 to 0; the first valid channel wins.
REQ-022 MODE=1: after a transfer from channel g, p SHALL become (g+1) mod N; otherwise p holds.
REQ-023 With N not a power of two, p SHALL never take a value of N or greater.
REQ-024 Grant SHALL be computed only from current-cycle inputs; no grant is held across cycles.

Reset
REQ-025 While rst_n=0: out_valid=0, out_data=0, out_sel=0, p=0, all in_ready=0; asserting rst_n=0 at any time SHALL take effect immediately.
REQ-026 A word held in the output register when reset asserts SHALL be discarded.
REQ-027 The first clock edge after rst_n rises SHALL be able to accept an input.

Configuration
REQ-028 Macro ARB_MUX_SEL_EN SHALL control a legacy direct-select mode.
REQ-029 With ARB_MUX_SEL_EN defined, the ports force_en (input, 1) and force_sel (input, clog2(N)) SHALL exist.
REQ-030 While force_en=1, channel force_sel SHALL be the only grant candidate, regardless of MODE, and p SHALL not update.
REQ-031 Without ARB_MUX_SEL_EN, neither port SHALL exist and arbitration alone SHALL decide the grant.

Structure
REQ-032 Package arb_mux_pkg SHALL hold the MODE_FIXED=0 and MODE_RR=1 constants and the clog2 helper function.
REQ-033 Sub-module arb_rr_grant SHALL compute the one-hot grant from request, pointer and MODE; arb_mux SHALL hold the output register and pointer.

Verification
REQ-034 MODE=0, N=4, in_valid=4'b1010 held, out_ready=1 -> channel 1 wins every cycle; out_sel=1.
REQ-035 MODE=1, N=4, in_valid=4'b1111 held, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles.
REQ-036 MODE=1, N=3, only channel 2 valid, then all three valid -> after the channel 2 grant, p=0 and the next winner is channel 0.
REQ-037 out_ready=0 for 3 cycles with out_data=32'hDEADBEEF -> output is stable and in_ready=0; on the cycle out_ready rises, the next word is accepted.
REQ-038 rst_n pulled low mid-burst (asynchronous, between edges) -> out_valid=0 immediately; after release, p=0 and channel 0 wins first.
REQ-039 ARB_MUX_SEL_EN defined, force_en=1, force_sel=2, in_valid=4'b0111 -> only channel 2 is granted and p does not change.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the arb_mux arbiter/mux slice.
package arb_mux_pkg;
  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Index width for n channels, never below 1 bit
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/arb_rr_grant.sv
// One-hot grant from request vector and search pointer (fixed priority or round-robin).
module arb_rr_grant
  import arb_mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int MODE = MODE_RR,
  localparam int PW  = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  logic [N-1:0] hi, pick;

  // Requests at or above ptr take precedence; if none, wrap to the lowest request.
  always_comb begin
    hi  = '0;
    gnt = '0;
    for (int i = 0; i < N; i++)
      hi[i] = req[i] && (MODE == MODE_RR) && (PW'(i) >= ptr);
    pick = (|hi) ? hi : req;
    for (int i = N - 1; i >= 0; i--)
      if (pick[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
      end
  end
endmodule

// File: rtl/arb_mux.sv
// N-channel arbitrating mux with a single output register and one-cycle latency.
// Optional legacy direct-select ports are enabled by defining ARB_MUX_SEL_EN.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int MODE  = MODE_RR,
  localparam int SW   = clog2(N)
) (
`ifdef ARB_MUX_SEL_EN
  input  logic              force_en,
  input  logic [SW-1:0]     force_sel,
`endif
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]      in_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic [SW-1:0]     out_sel,
  input  logic              out_ready
);
  logic             load, fire, force_act;
  logic [N-1:0]     cand, gnt;
  logic [SW-1:0]    p, gidx;
  logic [WIDTH-1:0] gdata;

  always_comb begin
    cand      = in_valid;
    force_act = 1'b0;
`ifdef ARB_MUX_SEL_EN
    force_act = force_en;
    if (force_en)
      for (int i = 0; i < N; i++)
        cand[i] = in_valid[i] && (SW'(i) == force_sel);
`endif
  end

  arb_rr_grant #(.N(N), .MODE(MODE)) u_grant (
    .req (cand),
    .ptr (p),
    .gnt (gnt)
  );

  assign load     = !out_valid || out_ready;
  // Gated by rst_n so no channel sees an accept while reset is held
  assign in_ready = (rst_n && load) ? gnt : '0;
  assign fire     = |in_ready;

  always_comb begin
    gidx  = '0;
    gdata = '0;
    for (int i = 0; i < N; i++)
      if (gnt[i]) begin
        gidx  = gidx | SW'(i);
        gdata = gdata | in_data[i*WIDTH +: WIDTH];
      end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      p         <= '0;
    end else begin
      if (load) begin
        out_valid <= fire;
        if (fire) begin
          out_data <= gdata;
          out_sel  <= gidx;
        end
      end
      // Explicit wrap keeps p below N for non-power-of-two N
      if (MODE == MODE_RR && fire && !force_act)
        p <= (gidx == SW'(N - 1)) ? '0 : gidx + 1'b1;
    end
  end
endmodule

// File: tb/tb_arb_mux.sv
// Randomized bench for arb_mux: three instances (N=4 RR, N=4 fixed, N=3 RR) vs a queue-free reference model.
module tb_arb_mux;
  import arb_mux_pkg::*;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0] v0, v1, ir0, ir1;
  logic [2:0] v2, ir2;
  logic [4*W-1:0] d0, d1;
  logic [3*W-1:0] d2;
  logic r0, r1, r2, ov0, ov1, ov2;
  logic [W-1:0] od0, od1, od2;
  logic [1:0] os0, os1, os2;
  logic fen;
  logic [1:0] fsel;

  arb_mux #(.WIDTH(W), .N(4), .MODE(MODE_RR)) u_rr (
`ifdef ARB_MUX_SEL_EN
    .force_en(fen), .force_sel(fsel),
`endif
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_data(d0), .in_ready(ir0),
    .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(r0));

  arb_mux #(.WIDTH(W), .N(4), .MODE(MODE_FIXED)) u_fx (
`ifdef ARB_MUX_SEL_EN
    .force_en(1'b0), .force_sel(2'b00),
`endif
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_data(d1), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(r1));

  arb_mux #(.WIDTH(W), .N(3), .MODE(MODE_RR)) u_rr3 (
`ifdef ARB_MUX_SEL_EN
    .force_en(1'b0), .force_sel(2'b00),
`endif
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_data(d2), .in_ready(ir2),
    .out_valid(ov2), .out_data(od2), .out_sel(os2), .out_ready(r2));

  int n_cmp = 0, n_err = 0;
  bit mv[3];
  logic [W-1:0] md[3];
  int ms[3], mp[3];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nch(int d); return (d == 2) ? 3 : 4; endfunction
  function automatic logic rdy(int d); return (d == 0) ? r0 : (d == 1) ? r1 : r2; endfunction
  function automatic logic [3:0] vld(int d);
    return (d == 0) ? v0 : (d == 1) ? v1 : {1'b0, v2};
  endfunction
  function automatic logic [W-1:0] dat(int d, int i);
    return (d == 0) ? d0[i*W +: W] : (d == 1) ? d1[i*W +: W] : d2[i*W +: W];
  endfunction

  // First requesting channel, scanning from the rotating start (or 0 in fixed mode)
  function automatic int winner(int d);
    logic [3:0] c;
    int st, i;
    c = vld(d);
    if (d == 0 && fen) c = c & (4'b0001 << fsel);
    st = (d == 1) ? 0 : mp[d];
    for (int k = 0; k < nch(d); k++) begin
      i = (st + k) % nch(d);
      if (c[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ir(int d);
    int w;
    w = winner(d);
    return ((!mv[d] || rdy(d)) && w >= 0) ? 4'(1 << w) : 4'h0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin mv[d] = 0; md[d] = '0; ms[d] = 0; mp[d] = 0; end
  endtask

  task automatic model_step();
    int w;
    for (int d = 0; d < 3; d++) begin
      w = winner(d);
      if (!mv[d] || rdy(d)) begin
        if (w >= 0) begin
          mv[d] = 1; md[d] = dat(d, w); ms[d] = w;
          if (d != 1 && !(d == 0 && fen)) mp[d] = (w + 1) % nch(d);
        end else mv[d] = 0;
      end
    end
  endtask

  task automatic chk_outs();
    chk("out_valid0", ov0, mv[0]); chk("out_data0", od0, md[0]); chk("out_sel0", os0, ms[0]);
    chk("out_valid1", ov1, mv[1]); chk("out_data1", od1, md[1]); chk("out_sel1", os1, ms[1]);
    chk("out_valid2", ov2, mv[2]); chk("out_data2", od2, md[2]); chk("out_sel2", os2, ms[2]);
  endtask

  // Inputs are driven at negedge before calling; checks in_ready, clocks, checks outputs
  task automatic tick();
    #1;
    chk("in_ready0", ir0, exp_ir(0));
    chk("in_ready1", ir1, exp_ir(1));
    chk("in_ready2", {1'b0, ir2}, exp_ir(2));
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk_outs();
  endtask

  task automatic rand_data();
    for (int i = 0; i < 4; i++) begin
      d0[i*W +: W] = $urandom; d1[i*W +: W] = $urandom;
      if (i < 3) d2[i*W +: W] = $urandom;
    end
  endtask

  task automatic rand_inputs();
    rand_data();
    v0 = 4'($urandom); v1 = 4'($urandom); v2 = 3'($urandom);
    r0 = ($urandom_range(0, 3) != 0); r1 = ($urandom_range(0, 3) != 0); r2 = ($urandom_range(0, 3) != 0);
`ifdef ARB_MUX_SEL_EN
    fen = ($urandom_range(0, 7) == 0); fsel = 2'($urandom);
`endif
  endtask

  int seq[5] = '{0, 1, 2, 3, 0};
  int pb;

  initial begin
    rst_n = 1'b0; fen = 1'b0; fsel = '0;
    v0 = 4'hf; v1 = 4'hf; v2 = 3'h7; r0 = 1; r1 = 1; r2 = 1;
    rand_data();
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", {ov0, ov1, ov2}, 3'b000);
    chk("rst_data", od0 | od1 | od2, 0);
    chk("rst_sel", {os0, os1, os2}, 6'd0);
    chk("rst_ready", {ir0, ir1, ir2}, 11'd0);
    rst_n = 1'b1;

    // Round-robin sweep, fixed priority with 1010, N=3 wrap after channel 2
    for (int k = 0; k < 5; k++) begin
      rand_data();
      v0 = 4'hf; v1 = 4'b1010; v2 = (k == 0) ? 3'b100 : 3'b111;
      tick();
      chk("rr_seq", os0, seq[k]);
      chk("fixed_sel", os1, 1);
      if (k == 0) chk("n3_ch2", os2, 2);
      if (k == 1) chk("n3_wrap", os2, 0);
    end

    // Backpressure hold
    rand_data(); v0 = 4'b0001; d0[W-1:0] = 32'hDEADBEEF; r0 = 1;
    tick();
    r0 = 0;
    for (int k = 0; k < 3; k++) begin
      rand_data(); v0 = 4'hf;
      tick();
      chk("stall_data", od0, 32'hDEADBEEF);
      chk("stall_ready", ir0, 0);
    end
    r0 = 1; v0 = 4'hf; rand_data();
    #1 chk("stall_release", |ir0, 1'b1);
    tick();

`ifdef ARB_MUX_SEL_EN
    pb = mp[0];
    fen = 1; fsel = 2; v0 = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      rand_data();
      #1 chk("force_ready", ir0, 4'b0100);
      tick();
    end
    fen = 0; v0 = 4'hf; rand_data();
    tick();
    chk("force_ptr_hold", os0, pb);
`endif

    for (int c = 0; c < 300; c++) begin rand_inputs(); tick(); end

    // Asynchronous reset landing between edges while outputs are full
    v0 = 4'hf; v1 = 4'hf; v2 = 3'h7; r0 = 0; r1 = 0; r2 = 0; fen = 0; rand_data();
    tick();
    @(posedge clk); model_step();
    #3 rst_n = 1'b0;
    #1;
    chk("async_valid", {ov0, ov1, ov2}, 3'b000);
    chk("async_ready", {ir0, ir1, ir2}, 11'd0);
    model_reset();
    @(negedge clk);
    chk_outs();
    rst_n = 1'b1; r0 = 1; r1 = 1; r2 = 1; rand_data();
    tick();
    chk("post_rst_first", os0, 0);

    for (int c = 0; c < 300; c++) begin rand_inputs(); tick(); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
